// File: rtl/axi_ram_pkg.sv
// Shared encodings, FSM state types and request legality check for the AXI burst RAM.
package axi_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} wState_e;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_DATA} rState_e;

    // A request is legal when the beat fits the bus, the burst type is defined,
    // and a WRAP burst has 2, 4, 8 or 16 beats.
    function automatic logic reqLegal(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst, input int unsigned laneBits);
        logic ok;
        ok = 1'b1;
        if (32'(size) > laneBits) ok = 1'b0;
        if (burst == 2'b11) ok = 1'b0;
        if (burst == BURST_WRAP &&
            !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] nextAddr_o
);

    localparam int XW = ADDR_WIDTH + 16;

    logic [XW-1:0] bytes;
    logic [XW-1:0] wrapMask;
    logic [XW-1:0] aligned;
    logic [XW-1:0] incr;

    // Wide intermediates so the wrap window never overflows before truncation.
    always_comb begin
        bytes      = XW'(1) << size_i;
        wrapMask   = (bytes * (XW'(len_i) + XW'(1))) - XW'(1);
        aligned    = XW'(addr_i) & ~(bytes - XW'(1));
        incr       = aligned + bytes;
        nextAddr_o = addr_i;
        case (burst_i)
            BURST_INCR: nextAddr_o = incr[ADDR_WIDTH-1:0];
            BURST_WRAP: nextAddr_o = ADDR_WIDTH'((aligned & ~wrapMask) | (incr & wrapMask));
            default:    nextAddr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM with FIXED/INCR/WRAP bursts, byte strobes, independent read and
// write channels, SLVERR on illegal requests or WLAST mismatch, and per-channel latency.
module axi_burst_ram
    import axi_ram_pkg::*;
#(
    parameter int ID_WIDTH      = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int BRESP_WIDTH   = 2,
    parameter int WR_MEM_DELAY  = 0,
    parameter int RD_MEM_DELAY  = 0,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int MEM_ADDR_SIZE = ADDR_WIDTH - $clog2(STROBE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STROBE_WIDTH-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [BRESP_WIDTH-1:0]  s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [BRESP_WIDTH-1:0]  s_axi_rresp,
    output logic                    s_axi_rlast
);

    localparam int          LANE_BITS   = $clog2(STROBE_WIDTH);
    localparam int          MEM_WORDS   = 2 ** MEM_ADDR_SIZE;
    localparam logic [15:0] WR_DLY_LAST = 16'(WR_MEM_DELAY - 1);
    localparam logic [15:0] RD_DLY_LAST = 16'(RD_MEM_DELAY - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    wState_e               wState_q, wState_d;
    logic [ID_WIDTH-1:0]   wId_q, wId_d;
    logic [ADDR_WIDTH-1:0] wAddr_q, wAddr_d, wNextAddr;
    logic [7:0]            wLen_q, wLen_d, wCnt_q, wCnt_d;
    logic [2:0]            wSize_q, wSize_d;
    logic [1:0]            wBurst_q, wBurst_d;
    logic [15:0]           wDly_q, wDly_d;
    logic                  wIllegal_q, wIllegal_d, wErr_q, wErr_d;
    logic                  wEn;

    rState_e               rState_q, rState_d;
    logic [ID_WIDTH-1:0]   rId_q, rId_d;
    logic [ADDR_WIDTH-1:0] rAddr_q, rAddr_d, rNextAddr, loadAddr;
    logic [7:0]            rLen_q, rLen_d, rCnt_q, rCnt_d;
    logic [2:0]            rSize_q, rSize_d;
    logic [1:0]            rBurst_q, rBurst_d;
    logic [15:0]           rDly_q, rDly_d;
    logic                  rIllegal_q, rIllegal_d, arIllegal;
    logic [DATA_WIDTH-1:0] rData_q, rData_d;
    logic [BRESP_WIDTH-1:0] rResp_q, rResp_d;
    logic                  rLast_q, rLast_d;
    logic                  loadEn, loadIll;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) wrAddrGen (
        .addr_i(wAddr_q), .len_i(wLen_q), .size_i(wSize_q), .burst_i(wBurst_q),
        .nextAddr_o(wNextAddr)
    );

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) rdAddrGen (
        .addr_i(rAddr_q), .len_i(rLen_q), .size_i(rSize_q), .burst_i(rBurst_q),
        .nextAddr_o(rNextAddr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState_q   <= W_IDLE;
            wId_q      <= '0;
            wAddr_q    <= '0;
            wLen_q     <= '0;
            wSize_q    <= '0;
            wBurst_q   <= '0;
            wCnt_q     <= '0;
            wDly_q     <= '0;
            wIllegal_q <= 1'b0;
            wErr_q     <= 1'b0;
        end else begin
            wState_q   <= wState_d;
            wId_q      <= wId_d;
            wAddr_q    <= wAddr_d;
            wLen_q     <= wLen_d;
            wSize_q    <= wSize_d;
            wBurst_q   <= wBurst_d;
            wCnt_q     <= wCnt_d;
            wDly_q     <= wDly_d;
            wIllegal_q <= wIllegal_d;
            wErr_q     <= wErr_d;
        end
    end

    // wErr_q collects both the illegal-request and the WLAST-mismatch cases.
    always_comb begin
        wState_d      = wState_q;
        wId_d         = wId_q;
        wAddr_d       = wAddr_q;
        wLen_d        = wLen_q;
        wSize_d       = wSize_q;
        wBurst_d      = wBurst_q;
        wCnt_d        = wCnt_q;
        wDly_d        = wDly_q;
        wIllegal_d    = wIllegal_q;
        wErr_d        = wErr_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wState_q)
            W_IDLE: begin
                s_axi_awready = !rst;
                if (s_axi_awvalid && !rst) begin
                    wId_d      = s_axi_awid;
                    wAddr_d    = s_axi_awaddr;
                    wLen_d     = s_axi_awlen;
                    wSize_d    = s_axi_awsize;
                    wBurst_d   = s_axi_awburst;
                    wCnt_d     = '0;
                    wIllegal_d = !reqLegal(s_axi_awlen, s_axi_awsize, s_axi_awburst, LANE_BITS);
                    wErr_d     = wIllegal_d;
                    wState_d   = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = !rst;
                if (s_axi_wvalid) begin
                    if (s_axi_wlast != (wCnt_q == wLen_q)) wErr_d = 1'b1;
                    wAddr_d = wNextAddr;
                    wCnt_d  = wCnt_q + 8'd1;
                    wDly_d  = '0;
                    if (wCnt_q == wLen_q) wState_d = (WR_MEM_DELAY == 0) ? W_RESP : W_DELAY;
                end
            end
            W_DELAY: begin
                wDly_d = wDly_q + 16'd1;
                if (wDly_q == WR_DLY_LAST) wState_d = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wState_d = W_IDLE;
            end
            default: wState_d = W_IDLE;
        endcase
    end

    assign s_axi_bid   = wId_q;
    assign s_axi_bresp = wErr_q ? BRESP_WIDTH'(RESP_SLVERR) : BRESP_WIDTH'(RESP_OKAY);
    assign wEn         = s_axi_wvalid && s_axi_wready && !wIllegal_q;

    always_ff @(posedge clk) begin
        if (wEn) begin
            for (int b = 0; b < STROBE_WIDTH; b++) begin
                if (s_axi_wstrb[b])
                    mem[wAddr_q[ADDR_WIDTH-1:LANE_BITS]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q   <= R_IDLE;
            rId_q      <= '0;
            rAddr_q    <= '0;
            rLen_q     <= '0;
            rSize_q    <= '0;
            rBurst_q   <= '0;
            rCnt_q     <= '0;
            rDly_q     <= '0;
            rIllegal_q <= 1'b0;
            rData_q    <= '0;
            rResp_q    <= '0;
            rLast_q    <= 1'b0;
        end else begin
            rState_q   <= rState_d;
            rId_q      <= rId_d;
            rAddr_q    <= rAddr_d;
            rLen_q     <= rLen_d;
            rSize_q    <= rSize_d;
            rBurst_q   <= rBurst_d;
            rCnt_q     <= rCnt_d;
            rDly_q     <= rDly_d;
            rIllegal_q <= rIllegal_d;
            rData_q    <= rData_d;
            rResp_q    <= rResp_d;
            rLast_q    <= rLast_d;
        end
    end

    // The read register samples memory before this edge's write lands, so a
    // same-word collision returns the old contents.
    always_comb begin
        rState_d      = rState_q;
        rId_d         = rId_q;
        rAddr_d       = rAddr_q;
        rLen_d        = rLen_q;
        rSize_d       = rSize_q;
        rBurst_d      = rBurst_q;
        rCnt_d        = rCnt_q;
        rDly_d        = rDly_q;
        rIllegal_d    = rIllegal_q;
        rData_d       = rData_q;
        rResp_d       = rResp_q;
        rLast_d       = rLast_q;
        loadEn        = 1'b0;
        loadAddr      = rAddr_q;
        loadIll       = rIllegal_q;
        arIllegal     = !reqLegal(s_axi_arlen, s_axi_arsize, s_axi_arburst, LANE_BITS);
        s_axi_arready = 1'b0;
        case (rState_q)
            R_IDLE: begin
                s_axi_arready = !rst;
                if (s_axi_arvalid && !rst) begin
                    rId_d      = s_axi_arid;
                    rAddr_d    = s_axi_araddr;
                    rLen_d     = s_axi_arlen;
                    rSize_d    = s_axi_arsize;
                    rBurst_d   = s_axi_arburst;
                    rCnt_d     = '0;
                    rDly_d     = '0;
                    rIllegal_d = arIllegal;
                    if (RD_MEM_DELAY == 0) begin
                        loadEn   = 1'b1;
                        loadAddr = s_axi_araddr;
                        loadIll  = arIllegal;
                        rLast_d  = (s_axi_arlen == 8'd0);
                        rState_d = R_DATA;
                    end else begin
                        rState_d = R_DELAY;
                    end
                end
            end
            R_DELAY: begin
                rDly_d = rDly_q + 16'd1;
                if (rDly_q == RD_DLY_LAST) begin
                    loadEn   = 1'b1;
                    rLast_d  = (rLen_q == 8'd0);
                    rState_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rCnt_q == rLen_q) begin
                        rLast_d  = 1'b0;
                        rState_d = R_IDLE;
                    end else begin
                        rCnt_d   = rCnt_q + 8'd1;
                        rAddr_d  = rNextAddr;
                        loadEn   = 1'b1;
                        loadAddr = rNextAddr;
                        rLast_d  = (rCnt_q + 8'd1 == rLen_q);
                    end
                end
            end
            default: rState_d = R_IDLE;
        endcase
        if (loadEn) begin
            rData_d = loadIll ? '0 : mem[loadAddr[ADDR_WIDTH-1:LANE_BITS]];
            rResp_d = loadIll ? BRESP_WIDTH'(RESP_SLVERR) : BRESP_WIDTH'(RESP_OKAY);
        end
    end

    assign s_axi_rvalid = (rState_q == R_DATA);
    assign s_axi_rid    = rId_q;
    assign s_axi_rdata  = rData_q;
    assign s_axi_rresp  = rResp_q;
    assign s_axi_rlast  = rLast_q;

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed bench for axi_burst_ram, built with a 3-cycle write latency and zero read latency.
module tb_axi_burst_ram;

    logic        clk, rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, bid, arid, rid;
    logic [7:0]  awaddr, awlen, araddr, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, wstrb, bresp, rresp;
    logic [15:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    int checks = 0;
    int errors = 0;

    logic [15:0] wData [16];
    logic [1:0]  wStrb [16];
    logic [15:0] rData [16];
    logic [1:0]  rResp [16];
    logic        rLast [16];

    axi_burst_ram #(
        .ID_WIDTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(16), .BRESP_WIDTH(2),
        .WR_MEM_DELAY(3), .RD_MEM_DELAY(0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write burst from wData/wStrb; lastBeat < 0 means WLAST on the final beat.
    task automatic writeBurst(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int lastBeat,
                              input int bStall, output logic [1:0] resp, output logic [3:0] bidSeen,
                              output int lat, output logic held);
        int n;
        held = 1'b1;
        @(negedge clk);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin errors++; $display("[TB] FAIL aw_timeout: awready=%b required 1", awready); end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wData[i]; wstrb = wStrb[i];
            wlast  = (lastBeat < 0) ? (i == int'(len)) : (i == lastBeat);
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) begin errors++; $display("[TB] FAIL w_timeout: wready=%b required 1", wready); end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        lat = 1;
        while (!bvalid && lat < 100) begin @(negedge clk); lat++; end
        if (!bvalid) begin errors++; $display("[TB] FAIL b_timeout: bvalid=%b required 1", bvalid); end
        resp = bresp; bidSeen = bid;
        for (int k = 0; k < bStall; k++) begin
            @(negedge clk);
            if (bvalid !== 1'b1) held = 1'b0;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Drives one read burst into rData/rResp/rLast; with stall, holds rready low 2 cycles per beat.
    task automatic readBurst(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic stall,
                             output logic [3:0] ridSeen, output logic firstValid, output logic stable);
        int n;
        stable = 1'b1;
        @(negedge clk);
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin errors++; $display("[TB] FAIL ar_timeout: arready=%b required 1", arready); end
        @(negedge clk);
        arvalid = 1'b0;
        firstValid = rvalid;
        ridSeen = rid;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            if (!rvalid) begin errors++; $display("[TB] FAIL r_timeout: rvalid=%b required 1", rvalid); end
            rData[i] = rdata; rResp[i] = rresp; rLast[i] = rlast;
            if (stall) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    if (rvalid !== 1'b1 || rdata !== rData[i] || rlast !== rLast[i] || rresp !== rResp[i])
                        stable = 1'b0;
                end
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: aw/w/b/ar/r/last=%b required 000000",
                     {awready, wready, bvalid, arready, rvalid, rlast});
        end
        checks++;
        if ({bid, bresp, rid, rresp, rdata} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: bid=%h bresp=%h rid=%h rresp=%h rdata=%h required all 0",
                     bid, bresp, rid, rresp, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_idle: awready=%b arready=%b required 1 1", awready, arready);
        end
    endtask

    task automatic test_incr;
        logic [15:0] exp [4];
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        exp = '{16'h0A0B, 16'h0C0D, 16'h1122, 16'h3344};
        for (int i = 0; i < 4; i++) begin wData[i] = exp[i]; wStrb[i] = 2'b11; end
        writeBurst(4'h5, 8'h00, 8'd3, 3'd1, 2'b01, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b00 || idSeen !== 4'h5) begin
            errors++; $display("[TB] FAIL incr_wr_resp: bresp=%h bid=%h required 0 5", resp, idSeen);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("[TB] FAIL wr_delay: bvalid after %0d cycles required 4", lat);
        end
        readBurst(4'h6, 8'h00, 8'd3, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        checks++;
        if (fv !== 1'b1 || idSeen !== 4'h6) begin
            errors++; $display("[TB] FAIL incr_rd_first: rvalid=%b rid=%h required 1 6", fv, idSeen);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rData[i] !== exp[i] || rResp[i] !== 2'b00 || rLast[i] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL incr_rd_beat%0d: data=%h resp=%h last=%b required %h 0 %b",
                         i, rData[i], rResp[i], rLast[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_narrow;
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        wData[0] = 16'h00AA; wStrb[0] = 2'b01;
        wData[1] = 16'hBB00; wStrb[1] = 2'b10;
        wData[2] = 16'h00CC; wStrb[2] = 2'b01;
        wData[3] = 16'hDD00; wStrb[3] = 2'b10;
        writeBurst(4'h1, 8'h10, 8'd3, 3'd0, 2'b01, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b00) begin
            errors++; $display("[TB] FAIL narrow_resp: bresp=%h required 0", resp);
        end
        readBurst(4'h1, 8'h10, 8'd1, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        checks++;
        if (rData[0] !== 16'hBBAA || rData[1] !== 16'hDDCC) begin
            errors++;
            $display("[TB] FAIL narrow_data: words=%h %h required BBAA DDCC", rData[0], rData[1]);
        end
    endtask

    task automatic test_wrap;
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        logic [15:0] lin [4];
        lin = '{16'h3003, 16'h4004, 16'h1001, 16'h2002};
        wData[0] = 16'h1001; wData[1] = 16'h2002; wData[2] = 16'h3003; wData[3] = 16'h4004;
        for (int i = 0; i < 4; i++) wStrb[i] = 2'b11;
        writeBurst(4'h2, 8'h24, 8'd3, 3'd1, 2'b10, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b00) begin
            errors++; $display("[TB] FAIL wrap_resp: bresp=%h required 0", resp);
        end
        readBurst(4'h2, 8'h20, 8'd3, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rData[i] !== lin[i]) begin
                errors++;
                $display("[TB] FAIL wrap_layout%0d: data=%h required %h", i, rData[i], lin[i]);
            end
        end
        readBurst(4'h2, 8'h24, 8'd3, 3'd1, 2'b10, 1'b0, idSeen, fv, st);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rData[i] !== wData[i] || rLast[i] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL wrap_read%0d: data=%h last=%b required %h %b",
                         i, rData[i], rLast[i], wData[i], (i == 3));
            end
        end
    endtask

    task automatic test_fixed;
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        wData[0] = 16'hAAAA; wData[1] = 16'hBBBB; wData[2] = 16'hCCCC;
        for (int i = 0; i < 3; i++) wStrb[i] = 2'b11;
        writeBurst(4'h3, 8'h2E, 8'd2, 3'd1, 2'b01, -1, 0, resp, idSeen, lat, held);
        wData[0] = 16'h1111; wData[1] = 16'h2222; wData[2] = 16'h3333;
        writeBurst(4'h3, 8'h30, 8'd2, 3'd1, 2'b00, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b00) begin
            errors++; $display("[TB] FAIL fixed_resp: bresp=%h required 0", resp);
        end
        readBurst(4'h3, 8'h2E, 8'd2, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        checks++;
        if (rData[0] !== 16'hAAAA || rData[1] !== 16'h3333 || rData[2] !== 16'hCCCC) begin
            errors++;
            $display("[TB] FAIL fixed_data: words=%h %h %h required AAAA 3333 CCCC",
                     rData[0], rData[1], rData[2]);
        end
    endtask

    task automatic test_errors;
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        wData[0] = 16'hFFFF; wStrb[0] = 2'b11;
        writeBurst(4'h4, 8'h00, 8'd0, 3'd2, 2'b01, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b10) begin
            errors++; $display("[TB] FAIL err_size_resp: bresp=%h required 2", resp);
        end
        readBurst(4'h4, 8'h00, 8'd0, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        checks++;
        if (rData[0] !== 16'h0A0B) begin
            errors++; $display("[TB] FAIL err_size_mem: data=%h required 0A0B", rData[0]);
        end
        readBurst(4'h9, 8'h00, 8'd1, 3'd1, 2'b11, 1'b0, idSeen, fv, st);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rData[i] !== 16'h0 || rResp[i] !== 2'b10 || rLast[i] !== (i == 1)) begin
                errors++;
                $display("[TB] FAIL err_burst_rd%0d: data=%h resp=%h last=%b required 0 2 %b",
                         i, rData[i], rResp[i], rLast[i], (i == 1));
            end
        end
        wData[0] = 16'h4141; wData[1] = 16'h4242; wData[2] = 16'h4343; wData[3] = 16'h4444;
        for (int i = 0; i < 4; i++) wStrb[i] = 2'b11;
        writeBurst(4'h7, 8'h40, 8'd3, 3'd1, 2'b01, 1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b10 || idSeen !== 4'h7) begin
            errors++; $display("[TB] FAIL early_wlast: bresp=%h bid=%h required 2 7", resp, idSeen);
        end
        readBurst(4'h7, 8'h40, 8'd3, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        checks++;
        if (rData[0] !== 16'h4141 || rData[3] !== 16'h4444 || rResp[0] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL early_wlast_mem: first=%h last=%h resp=%h required 4141 4444 0",
                     rData[0], rData[3], rResp[0]);
        end
        writeBurst(4'h8, 8'h48, 8'd1, 3'd1, 2'b01, 99, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b10) begin
            errors++; $display("[TB] FAIL missing_wlast: bresp=%h required 2", resp);
        end
        writeBurst(4'h8, 8'h60, 8'd2, 3'd1, 2'b10, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b10) begin
            errors++; $display("[TB] FAIL wrap_len_illegal: bresp=%h required 2", resp);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        logic [15:0] exp [4];
        exp = '{16'h0A0B, 16'h0C0D, 16'h1122, 16'h3344};
        readBurst(4'hA, 8'h00, 8'd3, 3'd1, 2'b01, 1'b1, idSeen, fv, st);
        checks++;
        if (st !== 1'b1) begin
            errors++; $display("[TB] FAIL r_stall_stable: stable=%b required 1", st);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rData[i] !== exp[i] || rLast[i] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL r_stall_beat%0d: data=%h last=%b required %h %b",
                         i, rData[i], rLast[i], exp[i], (i == 3));
            end
        end
        wData[0] = 16'h7070; wStrb[0] = 2'b11;
        writeBurst(4'hB, 8'h70, 8'd0, 3'd1, 2'b01, -1, 5, resp, idSeen, lat, held);
        checks++;
        if (held !== 1'b1 || resp !== 2'b00 || idSeen !== 4'hB) begin
            errors++;
            $display("[TB] FAIL b_stall: held=%b bresp=%h bid=%h required 1 0 B", held, resp, idSeen);
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0] resp; logic [3:0] idSeen; int lat; logic held, fv, st;
        @(negedge clk);
        awvalid = 1'b1; awid = 4'hC; awaddr = 8'h50; awlen = 8'd3; awsize = 3'd1; awburst = 2'b01;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 16'h7777; wstrb = 2'b11; wlast = 1'b0;
        @(negedge clk);
        wdata = 16'h8888;
        rst = 1'b1;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: aw/w/b/ar/r=%b required 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wData[0] = 16'h9999; wData[1] = 16'hAAAA; wStrb[0] = 2'b11; wStrb[1] = 2'b11;
        writeBurst(4'hD, 8'h52, 8'd1, 3'd1, 2'b01, -1, 0, resp, idSeen, lat, held);
        checks++;
        if (resp !== 2'b00 || idSeen !== 4'hD) begin
            errors++; $display("[TB] FAIL post_reset_wr: bresp=%h bid=%h required 0 D", resp, idSeen);
        end
        readBurst(4'hD, 8'h50, 8'd2, 3'd1, 2'b01, 1'b0, idSeen, fv, st);
        checks++;
        if (rData[0] !== 16'h7777 || rData[1] !== 16'h9999 || rData[2] !== 16'hAAAA) begin
            errors++;
            $display("[TB] FAIL post_reset_mem: words=%h %h %h required 7777 9999 AAAA",
                     rData[0], rData[1], rData[2]);
        end
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_incr();
        test_narrow();
        test_wrap();
        test_fixed();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_ram.md
Name: axi_burst_ram

Overview:
Parametrised AXI4 slave RAM; next generation of the team's single-mode AXI RAM. Supports FIXED/INCR/WRAP bursts, narrow transfers with byte strobes, and independent concurrent read and write channels. Gives SLVERR on illegal requests and WLAST mismatch, and has configurable per-channel memory latency. Sits behind the interconnect as a scratch memory and serves as the DUT for the updated AXI bench tasks.

Parameters:
ID_WIDTH, 4, width of AWID/BID/ARID/RID
ADDR_WIDTH, 8, byte address width; memory holds 2^ADDR_WIDTH bytes
DATA_WIDTH, 16, data bus width; power of two, >=16
BRESP_WIDTH, 2, width of BRESP/RRESP
WR_MEM_DELAY, 0, extra cycles between last W beat and BVALID
RD_MEM_DELAY, 0, extra cycles between AR handshake and first RVALID
STROBE_WIDTH, DATA_WIDTH/8, derived; number of byte lanes
MEM_ADDR_SIZE, ADDR_WIDTH-$clog2(STROBE_WIDTH), derived; word index width

Ports:
clk  in  1  single clock; everything on rising edge
rst  in  1  reset, asynchronous, active-high
s_axi_awvalid/awready  in/out  1  write address handshake
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  byte start address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_wvalid/wready  in/out  1  write data handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STROBE_WIDTH  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bvalid/bready  out/in  1  response handshake
s_axi_bid  out  ID_WIDTH  = captured awid
s_axi_bresp  out  BRESP_WIDTH  00 OKAY, 10 SLVERR
s_axi_arvalid/arready  in/out  1  read address handshake
s_axi_arid/araddr/arlen/arsize/arburst  in  as AW  read request
s_axi_rvalid/rready  out/in  1  read data handshake
s_axi_rid  out  ID_WIDTH  = captured arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  BRESP_WIDTH  per-beat response
s_axi_rlast  out  1  last read beat

Behaviour:
- Reset: all valids/readies, bid, bresp, rid, rdata, rresp, rlast = 0; both FSMs go to IDLE. Memory is not cleared. Reset mid-burst abandons the burst; beats already written stay in memory.
- Write FSM W_IDLE -> W_DATA -> W_DELAY -> W_RESP -> W_IDLE.
  - awready=1 only in W_IDLE; AW handshake captures id/addr/len/size/burst.
  - wready=1 only in W_DATA. Each W handshake writes the lanes with wstrb=1 at word addr>>log2(STROBE_WIDTH), same edge; the address generator then advances.
  - After exactly awlen+1 beats go to W_DELAY (skipped when WR_MEM_DELAY=0).
  - W_RESP holds bvalid until bready.
- Read FSM R_IDLE -> R_DELAY -> R_DATA -> R_IDLE.
  - arready=1 only in R_IDLE. R_DELAY lasts RD_MEM_DELAY cycles; min latency AR handshake -> RVALID is 1 cycle.
  - rdata is registered from memory; it is loaded on entry and after each R handshake.
  - rvalid/rdata/rresp/rlast stay stable while rready=0. rlast=1 on beat arlen+1.
- Address generation: bytes per beat = 1<<size; start aligned down to size.
  - FIXED: constant address.
  - INCR: +bytes, wraps modulo 2^ADDR_WIDTH.
  - WRAP: window = (len+1)*bytes aligned; wraps to window base.
- Illegal request: size > log2(STROBE_WIDTH), burst=11, or WRAP with len not in {1,3,7,15}.
  - Write: data accepted, nothing written, bresp=10.
  - Read: all beats rdata=0, rresp=10; rlast still timed normally.
- WLAST mismatch (wlast=1 before final beat, or 0 on final beat): burst still ends after awlen+1 beats; bresp=10; beats are written.
- Read and write handshakes on the same word in the same cycle: the read register gets the old data.

Decomposition:
- Package axi_ram_pkg: burst encodings, resp encodings (OKAY=00, SLVERR=10), W/R state enums, legality-check function.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, len, size, burst); instantiated once per channel.

Test Plan:
- INCR write awaddr=0x00 len=3 size=1 data 0A0B,0C0D,1122,3344 strb=11 -> bresp=00, bid=awid; read same -> identical data, rlast on beat 4 only.
- Narrow INCR write addr=0x10 len=3 size=0, strb 01,10,01,10, bytes AA,BB,CC,DD -> word8=BBAA, word9=DDCC.
- WRAP write addr=0x24 len=3 size=1 -> beats land at 0x24,0x26,0x20,0x22; read-back WRAP returns the same order.
- FIXED write addr=0x30 len=2, data 1111,2222,3333 -> word 0x18=3333, neighbours unchanged.
- Errors: awsize=2 -> bresp=10, memory unchanged; arburst=11 len=1 -> two beats rresp=10 rdata=0; early wlast on beat 2 of 4 -> bresp=10.
- Backpressure/reset: rready toggled -> rdata stable while stalled; bready low 5 cycles -> bvalid held; WR_MEM_DELAY=3 -> bvalid 4 cycles after last W; rst pulse mid write -> all valids 0 immediately, next burst completes OKAY.
